inst_queue: RTL and testbench

- Decoupling FIFO between the decoder and the scoreboard.
- Captures each valid decoded instruction bundle (the ID_TO_SB_WD-bit bus) and presents bundles in program order to the scoreboard through a valid/ready handshake.
- Generates the decoder's stall input and discards all queued instructions on a branch redirect.

---
 rtl/inst_queue.sv | 110 +++++++++++
 tb/tb_inst_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - decoder-to-scoreboard instruction FIFO with branch flush; optional empty-queue bypass via IQ_BYPASS_EN
module inst_queue #(
   parameter int DATA_WD = 137,
   parameter int DEPTH   = 8,
   parameter int PTR_WD  = 3
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               br_e,
   input  logic               in_valid,
   input  logic [DATA_WD-1:0] in_bus,
   output logic               stall,
   output logic               sb_valid,
   output logic [DATA_WD-1:0] sb_bus,
   input  logic               sb_ready,
   output logic [PTR_WD:0]    iq_count
);

   localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD+1)'(DEPTH);

   // entry storage (no reset: contents are meaningless while count is 0)
   logic [DATA_WD-1:0] mem [DEPTH];

   logic [PTR_WD-1:0] wptr;
   logic [PTR_WD-1:0] rptr;
   logic [PTR_WD:0]   count;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic wr_en;
   logic rd_adv;

   // count is the only source of full/empty
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // stall decodes registered count only; a flush releases it immediately
   assign stall = full & ~br_e;

   // a held bundle repeated while stalled is never qualified as a push
   assign push = in_valid & ~stall & ~br_e;
   assign pop  = sb_valid & sb_ready & ~br_e;

`ifdef IQ_BYPASS_EN
   logic bypass;

   // empty queue: present the incoming bundle directly to the scoreboard
   assign bypass   = empty & in_valid & ~br_e & resetn;
   assign sb_valid = (~empty | bypass) & ~br_e;
   assign sb_bus   = empty ? in_bus : mem[rptr];

   // a bypassed bundle taken in the same cycle never touches storage
   assign wr_en  = push & ~(bypass & sb_ready);
   assign rd_adv = pop & ~bypass;
`else
   // pure registered FIFO: a pushed bundle is visible one cycle later
   assign sb_valid = ~empty & ~br_e;
   assign sb_bus   = mem[rptr];

   assign wr_en  = push;
   assign rd_adv = pop;
`endif

   assign iq_count = count;

   // write the accepted bundle into the tail entry
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= in_bus;
      end
   end

   // write pointer: advances on push, power-of-two depth wraps naturally
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
      end else if (br_e) begin
         wptr <= '0;
      end else if (wr_en) begin
         wptr <= wptr + 1'b1;
      end
   end

   // read pointer: advances on pop of a stored entry
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rptr <= '0;
      end else if (br_e) begin
         rptr <= '0;
      end else if (rd_adv) begin
         rptr <= rptr + 1'b1;
      end
   end

   // occupancy: simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (br_e) begin
         count <= '0;
      end else if (wr_en && !rd_adv) begin
         count <= count + 1'b1;
      end else if (rd_adv && !wr_en) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue against a queue-based reference model
module tb_inst_queue;

   localparam int DATA_WD = 137;
   localparam int DEPTH   = 8;
   localparam int PTR_WD  = 3;
`ifdef IQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic               clk;
   logic               resetn;
   logic               br_e;
   logic               in_valid;
   logic [DATA_WD-1:0] in_bus;
   logic               stall;
   logic               sb_valid;
   logic [DATA_WD-1:0] sb_bus;
   logic               sb_ready;
   logic [PTR_WD:0]    iq_count;

   inst_queue #(.DATA_WD(DATA_WD), .DEPTH(DEPTH), .PTR_WD(PTR_WD)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .br_e     (br_e),
      .in_valid (in_valid),
      .in_bus   (in_bus),
      .stall    (stall),
      .sb_valid (sb_valid),
      .sb_bus   (sb_bus),
      .sb_ready (sb_ready),
      .iq_count (iq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   // reference model: program-order list of queued bundles
   logic [DATA_WD-1:0] q[$];
   logic               e_stall;
   logic               e_valid;
   logic [DATA_WD-1:0] e_bus;
   logic [PTR_WD:0]    e_cnt;

   function automatic logic [DATA_WD-1:0] mk(input logic [31:0] pc);
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      t[31:0] = pc;
      return t[DATA_WD-1:0];
   endfunction

   // let inputs settle mid-cycle and derive expected outputs from the model
   task automatic settle();
      #2;
      e_stall = (q.size() == DEPTH) && !br_e;
      e_valid = resetn && !br_e && ((q.size() != 0) || (BYP && in_valid));
      e_bus   = (q.size() != 0) ? q[0] : in_bus;
      e_cnt   = q.size();
   endtask

   // advance one clock and apply the queue rules to the model
   task automatic tick();
      bit was_full;
      @(posedge clk);
      if (!resetn || br_e) begin
         q.delete();
      end else begin
         was_full = (q.size() == DEPTH);
         if (BYP && q.size() == 0 && in_valid) begin
            if (!sb_ready) q.push_back(in_bus);
         end else begin
            if (q.size() != 0 && sb_ready) void'(q.pop_front());
            if (in_valid && !was_full) q.push_back(in_bus);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; br_e = 1'b0; in_valid = 1'b1; sb_ready = 1'b1;
      in_bus = mk(32'hBFC0_0000);
      tick();
      for (int i = 0; i < 2; i++) begin
         settle();
         nvec++;
         if ({stall, sb_valid, iq_count} !== 6'b0) begin
            nmis++;
            $display("FAIL reset_outputs: stall=%b sb_valid=%b iq_count=%0d, expected all 0", stall, sb_valid, iq_count);
         end
         tick();
      end
      resetn = 1'b1; sb_ready = 1'b0; in_valid = 1'b1;
      in_bus = mk(32'hBFC0_0000);
      settle();
      tick();
      in_valid = 1'b0;
      settle();
      nvec++;
      if (!(sb_valid === 1'b1 && sb_bus[31:0] === 32'hBFC0_0000 && iq_count === 4'd1)) begin
         nmis++;
         $display("FAIL reset_first_push: sb_valid=%b pc=%h cnt=%0d, expected 1 bfc00000 1", sb_valid, sb_bus[31:0], iq_count);
      end
      sb_ready = 1'b1;
      settle();
      tick();
      sb_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [DATA_WD-1:0] held;
      sb_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i < 8) in_bus = mk(32'h100 + 32'(4 * i));
         else if (i == 8) begin held = mk(32'h120); in_bus = held; end
         settle();
         nvec++;
         if ({stall, sb_valid, iq_count} !== {e_stall, e_valid, e_cnt}) begin
            nmis++;
            $display("FAIL fill_ctl: got %b %b %0d, expected %b %b %0d", stall, sb_valid, iq_count, e_stall, e_valid, e_cnt);
         end
         if (i >= 8) begin
            nvec++;
            if (stall !== 1'b1 || iq_count !== 4'd8) begin
               nmis++;
               $display("FAIL fill_full: stall=%b cnt=%0d, expected 1 8", stall, iq_count);
            end
         end
         tick();
      end
      sb_ready = 1'b1;
      settle();
      nvec++;
      if (sb_bus[31:0] !== 32'h100) begin
         nmis++;
         $display("FAIL fill_pop_head: pc=%h, expected 100", sb_bus[31:0]);
      end
      tick();
      sb_ready = 1'b0;
      settle();
      nvec++;
      if (stall !== 1'b0 || iq_count !== 4'd7) begin
         nmis++;
         $display("FAIL fill_release: stall=%b cnt=%0d, expected 0 7", stall, iq_count);
      end
      tick();
      in_valid = 1'b0;
      sb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         nvec++;
         if (sb_valid !== 1'b1 || sb_bus[31:0] !== 32'h104 + 32'(4 * i) || (i == 0 && iq_count !== 4'd8)) begin
            nmis++;
            $display("FAIL fill_drain[%0d]: valid=%b pc=%h cnt=%0d, expected 1 %h", i, sb_valid, sb_bus[31:0], iq_count, 32'h104 + 32'(4 * i));
         end
         tick();
      end
      settle();
      nvec++;
      if (sb_valid !== 1'b0 || iq_count !== 4'd0) begin
         nmis++;
         $display("FAIL fill_empty: valid=%b cnt=%0d, expected 0 0", sb_valid, iq_count);
      end
      sb_ready = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] want_pc;
      want_pc = 32'h1000;
      sb_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_bus = mk(32'h1000 + 32'(4 * i));
         settle();
         if (sb_valid === 1'b1) begin
            nvec++;
            if (sb_bus[31:0] !== want_pc) begin
               nmis++;
               $display("FAIL stream_order[%0d]: pc=%h, expected %h", i, sb_bus[31:0], want_pc);
            end
            want_pc = want_pc + 32'd4;
         end
         if (i > 0) begin
            nvec++;
            if (iq_count !== (BYP ? 4'd0 : 4'd1)) begin
               nmis++;
               $display("FAIL stream_count[%0d]: cnt=%0d, expected %0d", i, iq_count, BYP ? 0 : 1);
            end
         end
         tick();
      end
      nvec++;
      if (want_pc !== (BYP ? 32'h1050 : 32'h104C)) begin
         nmis++;
         $display("FAIL stream_total: next pc %h, expected %h", want_pc, BYP ? 32'h1050 : 32'h104C);
      end
      in_valid = 1'b0;
      settle();
      tick();
      sb_ready = 1'b0;
   endtask

   task automatic test_flush();
      sb_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_bus = mk(32'h180 + 32'(4 * i));
         settle();
         tick();
      end
      br_e = 1'b1; sb_ready = 1'b1; in_bus = mk(32'h1FC);
      settle();
      nvec++;
      if (sb_valid !== 1'b0 || stall !== 1'b0 || iq_count !== 4'd5) begin
         nmis++;
         $display("FAIL flush_cycle: valid=%b stall=%b cnt=%0d, expected 0 0 5", sb_valid, stall, iq_count);
      end
      tick();
      br_e = 1'b0; in_valid = 1'b0; sb_ready = 1'b0;
      settle();
      nvec++;
      if (sb_valid !== 1'b0 || iq_count !== 4'd0) begin
         nmis++;
         $display("FAIL flush_after: valid=%b cnt=%0d, expected 0 0", sb_valid, iq_count);
      end
      in_valid = 1'b1; in_bus = mk(32'h200);
      settle();
      tick();
      in_valid = 1'b0;
      settle();
      nvec++;
      if (sb_valid !== 1'b1 || sb_bus[31:0] !== 32'h200 || iq_count !== 4'd1) begin
         nmis++;
         $display("FAIL flush_next_head: valid=%b pc=%h cnt=%0d, expected 1 200 1", sb_valid, sb_bus[31:0], iq_count);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_bus = mk(32'h204 + 32'(4 * i));
         settle();
         tick();
      end
      settle();
      nvec++;
      if (stall !== 1'b1 || iq_count !== 4'd8) begin
         nmis++;
         $display("FAIL flush_full_pre: stall=%b cnt=%0d, expected 1 8", stall, iq_count);
      end
      br_e = 1'b1;
      settle();
      nvec++;
      if (stall !== 1'b0) begin
         nmis++;
         $display("FAIL flush_full_stall: stall=%b, expected 0", stall);
      end
      tick();
      br_e = 1'b0; in_valid = 1'b0;
      settle();
      nvec++;
      if (iq_count !== 4'd0 || stall !== 1'b0) begin
         nmis++;
         $display("FAIL flush_full_after: cnt=%0d stall=%b, expected 0 0", iq_count, stall);
      end
   endtask

   task automatic test_empty_pop();
      in_valid = 1'b0; sb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         nvec++;
         if (sb_valid !== 1'b0 || iq_count !== 4'd0) begin
            nmis++;
            $display("FAIL empty_pop[%0d]: valid=%b cnt=%0d, expected 0 0", i, sb_valid, iq_count);
         end
         tick();
      end
`ifdef IQ_BYPASS_EN
      in_valid = 1'b1; in_bus = mk(32'h300);
      settle();
      nvec++;
      if (sb_valid !== 1'b1 || sb_bus[31:0] !== 32'h300) begin
         nmis++;
         $display("FAIL bypass_same_cycle: valid=%b pc=%h, expected 1 300", sb_valid, sb_bus[31:0]);
      end
      tick();
      in_valid = 1'b0;
      settle();
      nvec++;
      if (iq_count !== 4'd0 || sb_valid !== 1'b0) begin
         nmis++;
         $display("FAIL bypass_no_store: cnt=%0d valid=%b, expected 0 0", iq_count, sb_valid);
      end
`endif
      sb_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom % 4) != 0;
         sb_ready = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         br_e     = ($urandom % 24) == 0;
         in_bus   = mk($urandom());
         settle();
         nvec++;
         if ({stall, sb_valid, iq_count} !== {e_stall, e_valid, e_cnt}) begin
            nmis++;
            $display("FAIL random_ctl[%0d]: got %b %b %0d, expected %b %b %0d", i, stall, sb_valid, iq_count, e_stall, e_valid, e_cnt);
         end
         if (e_valid) begin
            nvec++;
            if (sb_bus !== e_bus) begin
               nmis++;
               $display("FAIL random_bus[%0d]: got %h, expected %h", i, sb_bus, e_bus);
            end
         end
         tick();
      end
      br_e = 1'b0;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; sb_ready = 1'b0; br_e = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_bus = mk(32'h3F0 + 32'(4 * i));
         settle();
         tick();
      end
      in_valid = 1'b0;
      settle();
      resetn = 1'b0;
      #1;
      nvec++;
      if (iq_count !== 4'd0 || sb_valid !== 1'b0 || stall !== 1'b0) begin
         nmis++;
         $display("FAIL async_reset: cnt=%0d valid=%b stall=%b before any edge, expected 0 0 0", iq_count, sb_valid, stall);
      end
      tick();
      resetn = 1'b1; in_valid = 1'b1; in_bus = mk(32'h400);
      settle();
      tick();
      in_valid = 1'b0;
      settle();
      nvec++;
      if (sb_valid !== 1'b1 || sb_bus !== e_bus || sb_bus[31:0] !== 32'h400 || iq_count !== 4'd1) begin
         nmis++;
         $display("FAIL async_reset_push: valid=%b pc=%h cnt=%0d, expected 1 400 1", sb_valid, sb_bus[31:0], iq_count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_flush();
      test_empty_pop();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
